// File: rtl/lvds_pattern_gen.sv
// Multi-mode test-pattern generator for the dual-channel LVDS panel path.
// Turns serialiser x/y coordinates into registered odd/even 24-bit RGB, one cycle later.
module lvds_pattern_gen #(
    parameter int unsigned H_ACTIVE    = 960,
    parameter int unsigned V_ACTIVE    = 1200,
    parameter int unsigned COORD_W     = 12,
    parameter int unsigned DUAL        = 1,
    parameter int unsigned BAR_STEP    = 1,
    parameter int unsigned BAR_SHIFT   = 0,
    parameter int unsigned AUTO_SHIFT  = 7,
    parameter int unsigned CHECK_SHIFT = 5,
    parameter int unsigned GRID_SHIFT  = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [2:0]         i_mode,
    input  logic               i_auto,
    input  logic [23:0]        i_solid_color,
    output logic [23:0]        o_color,
    output logic [23:0]        o_color_even,
    output logic               o_frame_tick,
    output logic [2:0]         o_mode
);

    // One extra bit so dual-pixel columns (up to 2*H_ACTIVE) fit.
    localparam int unsigned CW    = COORD_W + 1;
    localparam int unsigned WIDTH = (DUAL != 0) ? 2 * H_ACTIVE : H_ACTIVE;

    localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [CW-1:0] V_C      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] LAST_ROW = CW'(V_ACTIVE - 1);

    localparam logic [CW-1:0] T1 = CW'(1 * WIDTH / 8);
    localparam logic [CW-1:0] T2 = CW'(2 * WIDTH / 8);
    localparam logic [CW-1:0] T3 = CW'(3 * WIDTH / 8);
    localparam logic [CW-1:0] T4 = CW'(4 * WIDTH / 8);
    localparam logic [CW-1:0] T5 = CW'(5 * WIDTH / 8);
    localparam logic [CW-1:0] T6 = CW'(6 * WIDTH / 8);
    localparam logic [CW-1:0] T7 = CW'(7 * WIDTH / 8);

    localparam logic [CW:0]   BAR_STEP_C = (CW + 1)'(BAR_STEP);
    localparam logic [CW:0]   WIDTH_X    = (CW + 1)'(WIDTH);
    localparam logic [15:0]   BAR_LIM    = 16'((1 << BAR_SHIFT) - 1);
    localparam logic [15:0]   AUTO_LIM   = 16'((1 << AUTO_SHIFT) - 1);

    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] BLACK   = 24'h000000;

    logic               prev_zero_q;
    logic               tick_q;
    logic [2:0]         mode_q,      mode_d;
    logic [2:0]         auto_idx_q,  auto_idx_d;
    logic [15:0]        auto_cnt_q,  auto_cnt_d;
    logic [15:0]        bar_cnt_q,   bar_cnt_d;
    logic [CW-1:0]      bar_q,       bar_d;
    logic [23:0]        color_q,     color_d;
    logic [23:0]        color_even_q, color_even_d;

    logic               at_zero;
    logic               tick;
    logic [CW:0]        bar_sum;
    logic [CW-1:0]      col_odd;
    logic [CW-1:0]      col_even;

    function automatic logic [23:0] pixel(input logic [CW-1:0]      col,
                                          input logic [COORD_W-1:0] row,
                                          input logic [2:0]         mode,
                                          input logic [CW-1:0]      bar,
                                          input logic [23:0]        solid);
        logic [23:0]   p;
        logic [CW-1:0] rowx;
        p    = BLACK;
        rowx = {1'b0, row};
        if (col < WIDTH_C && rowx < V_C) begin
            case (mode)
                3'd0: p = solid;
                3'd1: begin
                    if (col == '0 || col == LAST_COL || col == bar) begin
                        p = WHITE;
                    end else if (rowx == '0 || rowx == LAST_ROW) begin
                        p = RED;
                    end else begin
                        p = GREEN;
                    end
                end
                3'd2: begin
                    if (col < T1)      p = WHITE;
                    else if (col < T2) p = YELLOW;
                    else if (col < T3) p = CYAN;
                    else if (col < T4) p = GREEN;
                    else if (col < T5) p = MAGENTA;
                    else if (col < T6) p = RED;
                    else if (col < T7) p = BLUE;
                    else               p = BLACK;
                end
                3'd3: p = {3{col[7:0]}};
                3'd4: p = (col[CHECK_SHIFT] ^ rowx[CHECK_SHIFT]) ? WHITE : BLACK;
                3'd5: begin
                    if (col[GRID_SHIFT-1:0] == '0 || rowx[GRID_SHIFT-1:0] == '0) begin
                        p = WHITE;
                    end else if (col == bar) begin
                        p = RED;
                    end else begin
                        p = BLACK;
                    end
                end
                default: p = BLACK;
            endcase
        end
        return p;
    endfunction

    assign col_odd  = (DUAL != 0) ? {i_x, 1'b0} : {1'b0, i_x};
    assign col_even = (DUAL != 0) ? {i_x, 1'b1} : {1'b0, i_x};

    always_comb begin
        at_zero    = (i_x == '0) && (i_y == '0);
        tick       = at_zero && !prev_zero_q;
        mode_d     = mode_q;
        auto_idx_d = auto_idx_q;
        auto_cnt_d = auto_cnt_q;
        bar_cnt_d  = bar_cnt_q;
        bar_d      = bar_q;
        bar_sum    = {1'b0, bar_q} + BAR_STEP_C;

        if (tick) begin
            if (auto_cnt_q == AUTO_LIM) begin
                auto_cnt_d = '0;
                auto_idx_d = (auto_idx_q == 3'd5) ? 3'd0 : auto_idx_q + 3'd1;
            end else begin
                auto_cnt_d = auto_cnt_q + 16'd1;
            end

            if (bar_cnt_q == BAR_LIM) begin
                bar_cnt_d = '0;
                // Wrap straight to zero rather than keeping the overshoot.
                bar_d     = (bar_sum >= WIDTH_X) ? '0 : bar_sum[CW-1:0];
            end else begin
                bar_cnt_d = bar_cnt_q + 16'd1;
            end

            mode_d = i_auto ? auto_idx_d : i_mode;
        end

        // The tick cycle already renders with the newly latched mode.
        color_d      = pixel(col_odd,  i_y, mode_d, bar_q, i_solid_color);
        color_even_d = pixel(col_even, i_y, mode_d, bar_q, i_solid_color);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_zero_q  <= 1'b0;
            tick_q       <= 1'b0;
            mode_q       <= 3'd0;
            auto_idx_q   <= 3'd0;
            auto_cnt_q   <= '0;
            bar_cnt_q    <= '0;
            bar_q        <= '0;
            color_q      <= BLACK;
            color_even_q <= BLACK;
        end else begin
            prev_zero_q  <= at_zero;
            tick_q       <= tick;
            mode_q       <= mode_d;
            auto_idx_q   <= auto_idx_d;
            auto_cnt_q   <= auto_cnt_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_q        <= bar_d;
            color_q      <= color_d;
            color_even_q <= color_even_d;
        end
    end

    assign o_color      = color_q;
    assign o_color_even = color_even_q;
    assign o_frame_tick = tick_q;
    assign o_mode       = mode_q;

endmodule
